microsequencer: RTL
===================

Name: microsequencer

Overview:
- Control-unit state register and next-state logic. Sits directly downstream of the instruction decoder that maps a fetched instruction to a 10-bit start state number.
- Each cycle it selects the next control state from one of these sources: decoder state, incremented state, microstore literal, return register, or a fixed fetch/fault vector.
- It also stalls on memory handshakes with a bounded timeout.
- The current state drives the microstore address that produces every datapath control signal.

Parameters:
- STATE_W, 10, width of state numbers (must match decoder output width)
- FETCH_STATE, 10'd1, first state of the instruction-fetch sequence
- UNDEF_STATE, 10'd2, state entered when the decoder returns state 0 (unimplemented instruction)
- FAULT_STATE, 10'd3, state entered on memory timeout
- MOC_TIMEOUT, 16, max cycles spent waiting for MOC before a fault; range 1..255

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- decoder_state  in  STATE_W  start state from the instruction decoder; 0 = unimplemented
- ns_sel  in  3  next-state select field of the current microinstruction
- cr_addr  in  STATE_W  literal target state field of the current microinstruction
- cond_true  in  1  condition-code tester result for the current instruction
- moc  in  1  memory operation complete (memory handshake ack)
- state  out  STATE_W  current control state (microstore address)
- ret_state  out  STATE_W  return register contents
- waiting  out  1  high while in a MEMWAIT cycle with moc low
- mem_fault  out  1  one-cycle pulse on the cycle the timeout redirect is taken

Behaviour:
- Clocking and reset:
  - All registers update on the rising clk edge only.
  - reset is synchronous, active-high, and dominates every ns_sel action.
  - Reset values: state = 0, ret_state = 0, wait counter = 0, mem_fault = 0. waiting is combinational and therefore 0 after reset.
- Default microstore action: state 0 is the reset state. The microstore issues ns_sel = FETCH at state 0, so the cycle after reset deasserts, state = FETCH_STATE.
- ns_sel decode (each applied at the next rising edge):
  - 0 DECODE: state <= (decoder_state == 0) ? UNDEF_STATE : decoder_state.
  - 1 INC: state <= state + 1, modulo 2^STATE_W. 1023 wraps to 0 and is not an error.
  - 2 JUMP: state <= cr_addr.
  - 3 CBRANCH: state <= cond_true ? cr_addr : state + 1.
  - 4 MEMWAIT:
    - If moc = 1: state <= state + 1 and the counter clears.
    - Else if counter == MOC_TIMEOUT-1: state <= FAULT_STATE, the counter clears, and mem_fault pulses high for exactly that one cycle.
    - Otherwise: state holds and the counter increments.
  - 5 CALL: ret_state <= state + 1; state <= cr_addr. The return register is one level deep; a nested CALL overwrites it.
  - 6 RET: state <= ret_state. ret_state is unchanged.
  - 7 FETCH: state <= FETCH_STATE.
- Wait counter:
  - 8 bits.
  - Clears on any cycle where ns_sel != MEMWAIT.
  - moc arriving on the same cycle the counter reaches MOC_TIMEOUT-1 counts as success: advance, no fault.
- waiting = (ns_sel == 4) && !moc && !reset. It is combinational, for datapath hold and debug.
- Latency:
  - Next state is visible one cycle after the ns_sel/inputs sample.
  - decoder_state is sampled only on DECODE cycles; changes at other times have no effect.
- Timing contract: ns_sel and cr_addr must be valid by the rising edge in every cycle. They are microstore outputs addressed by state and are treated as combinational from state.
- Reset mid-MEMWAIT: counter clears, state = 0, no mem_fault pulse.
- Unknown values: an X/Z ns_sel is not handled; the verification bench checks that ns_sel is never X after reset.

Test Plan:
- Reset then DECODE: reset for 2 cycles; ns_sel = 7 -> state = 1. Then ns_sel = 0 with decoder_state = 10'd37 -> state = 37 next cycle. Repeat with decoder_state = 0 -> state = 2.
- INC wrap and JUMP:
  - Force state 1023 via JUMP cr_addr = 1023, then INC -> state = 0.
  - CBRANCH at state 40, cr_addr = 100: cond_true = 1 -> state = 100; cond_true = 0 -> state = 41.
- MEMWAIT success: at state 50 with ns_sel = 4, moc low for 5 cycles then high -> state holds 50 and waiting = 1 for 5 cycles, then state = 51 with waiting = 0.
- MEMWAIT timeout:
  - With MOC_TIMEOUT = 16 and moc held low, state holds 50 for 15 cycles, then becomes 3 with mem_fault = 1 for exactly one cycle.
  - Boundary: moc = 1 on the 16th cycle -> state = 51, no fault.
- CALL/RET: at state 60, CALL with cr_addr = 200 -> state = 200, ret_state = 61. Two INCs -> 202. RET -> state = 61.
- Reset mid-wait: assert reset on the 7th MEMWAIT cycle -> next state = 0, mem_fault stays 0. After release, MEMWAIT restarts with the counter at 0; the fault occurs no earlier than 16 cycles.

Source files
------------

// File: rtl/microsequencer.sv
// microsequencer: control-state register with next-state select, one-level return register and bounded MOC wait
module microsequencer #(
  parameter int STATE_W = 10,
  parameter logic [STATE_W-1:0] FETCH_STATE = 10'd1,
  parameter logic [STATE_W-1:0] UNDEF_STATE = 10'd2,
  parameter logic [STATE_W-1:0] FAULT_STATE = 10'd3,
  parameter int MOC_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] decoder_state,
  input  logic [2:0]         ns_sel,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic               cond_true,
  input  logic               moc,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] ret_state,
  output logic               waiting,
  output logic               mem_fault
);
  localparam logic [7:0] LAST = 8'(MOC_TIMEOUT - 1);
  logic [7:0] cnt;
  logic [STATE_W-1:0] inc, nxt;
  logic memwait, tmo;
  always_comb begin
    inc = state + STATE_W'(1);
    memwait = ns_sel == 3'd4;
    tmo = memwait && !moc && cnt == LAST;
    nxt = ns_sel == 3'd0 ? (decoder_state == '0 ? UNDEF_STATE : decoder_state) :
          ns_sel == 3'd1 ? inc :
          ns_sel == 3'd2 ? cr_addr :
          ns_sel == 3'd3 ? (cond_true ? cr_addr : inc) :
          ns_sel == 3'd4 ? (moc ? inc : tmo ? FAULT_STATE : state) :
          ns_sel == 3'd5 ? cr_addr :
          ns_sel == 3'd6 ? ret_state : FETCH_STATE;
  end
  assign waiting = memwait && !moc && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
      ret_state <= '0;
      cnt <= '0;
      mem_fault <= 1'b0;
    end else begin
      state <= nxt;
      ret_state <= ns_sel == 3'd5 ? inc : ret_state;
      cnt <= (memwait && !moc && !tmo) ? cnt + 8'd1 : '0;
      mem_fault <= tmo;
    end
  end
endmodule
